// File: rtl/entity_line_renderer_if.sv
// Bundles the request, entity RAM read port and line-buffer write port of the line renderer.
// The renderer (slave) responds to requests from the controller (master) and reads entity records.
// Contains no logic; each signal is driven by exactly one side.
interface entity_line_renderer_if;
    logic        line_start;
    logic [8:0]  line_y;
    logic [7:0]  entities_number;
    logic [7:0]  address_read_ent;
    logic [20:0] data_read_ent;
    logic [8:0]  lb_address;
    logic [2:0]  lb_data;
    logic        lb_wren;
    logic        busy;
    logic        line_done;

    modport slave (
        input  line_start, line_y, entities_number, data_read_ent,
        output address_read_ent, lb_address, lb_data, lb_wren, busy, line_done
    );

    modport master (
        output line_start, line_y, entities_number, data_read_ent,
        input  address_read_ent, lb_address, lb_data, lb_wren, busy, line_done
    );
endinterface

// File: rtl/entity_line_renderer.sv
// Renders one 480-pixel line from a list of 48x48 entity records into a line buffer (ENT_CLEAR_EN adds a clear pass).
// Latency line_start->line_done: 2 + (480 if cleared) + 3 per record + 48 per record hit.
// No backpressure: line_start is ignored while busy; RAM data is expected exactly one cycle after the address.
module entity_line_renderer (
    input  logic                        i_clk,
    input  logic                        i_reset,
    entity_line_renderer_if.slave       bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_WAIT,
        S_CHECK,
        S_PAINT,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [8:0]  r_line_y;
    logic [7:0]  r_ent_num;
    logic [7:0]  r_index;
    logic [9:0]  r_col;        // paint column, also the sweep column of the clear pass
    logic [5:0]  r_k;          // pixel count within one 48-wide paint
    logic [2:0]  r_type;

    logic [7:0]  r_address_read_ent;
    logic [8:0]  r_lb_address;
    logic [2:0]  r_lb_data;
    logic        r_lb_wren;
    logic        r_busy;
    logic        r_line_done;

    logic [2:0]  w_type;
    logic [9:0]  w_row;
    logic [9:0]  w_row_end;
    logic [9:0]  w_colpos;
    logic [9:0]  w_y10;
    logic        w_hit;
    logic        w_last;

    // Record decode and hit test, all in 10 bits so row_pos+48 never wraps.
    always_comb begin
        w_type    = bus.data_read_ent[20:18];
        w_row     = {1'b0, bus.data_read_ent[17:9]};
        w_colpos  = {1'b0, bus.data_read_ent[8:0]};
        w_y10     = {1'b0, r_line_y};
        w_row_end = w_row + 10'd48;
        w_hit     = (w_type != 3'b110) && (w_type != 3'b111) &&
                    (w_y10 >= w_row) && (w_y10 < w_row_end);
        w_last    = ({1'b0, r_index} + 9'd1) == {1'b0, r_ent_num};
    end

    // Control FSM; every output is a register set from the state being left, so outputs trail the state by one cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state            <= S_IDLE;
            r_line_y           <= '0;
            r_ent_num          <= '0;
            r_index            <= '0;
            r_col              <= '0;
            r_k                <= '0;
            r_type             <= '0;
            r_address_read_ent <= '0;
            r_lb_address       <= '0;
            r_lb_data          <= '0;
            r_lb_wren          <= 1'b0;
            r_busy             <= 1'b0;
            r_line_done        <= 1'b0;
        end else begin
            r_lb_wren   <= 1'b0;
            r_line_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.line_start) begin
                        r_line_y  <= bus.line_y;
                        r_ent_num <= bus.entities_number;
                        r_index   <= '0;
                        r_col     <= '0;
                        r_busy    <= 1'b1;
`ifdef ENT_CLEAR_EN
                        r_state   <= S_CLEAR;
`else
                        r_state   <= (bus.entities_number == 8'd0) ? S_DONE : S_FETCH;
`endif
                    end
                end
`ifdef ENT_CLEAR_EN
                S_CLEAR: begin
                    r_lb_wren    <= 1'b1;
                    r_lb_address <= r_col[8:0];
                    r_lb_data    <= 3'd0;
                    if (r_col == 10'd479) begin
                        r_col   <= '0;
                        r_state <= (r_ent_num == 8'd0) ? S_DONE : S_FETCH;
                    end else begin
                        r_col   <= r_col + 10'd1;
                    end
                end
`endif
                S_FETCH: begin
                    r_address_read_ent <= r_index;
                    r_state            <= S_WAIT;
                end
                S_WAIT: begin
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    if (w_hit) begin
                        r_col   <= w_colpos;
                        r_type  <= w_type;
                        r_k     <= '0;
                        r_state <= S_PAINT;
                    end else if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_index <= r_index + 8'd1;
                        r_state <= S_FETCH;
                    end
                end
                S_PAINT: begin
                    // Columns past the right edge still take a cycle but write nothing.
                    r_lb_wren    <= (r_col < 10'd480);
                    r_lb_address <= r_col[8:0];
                    r_lb_data    <= r_type;
                    r_col        <= r_col + 10'd1;
                    r_k          <= r_k + 6'd1;
                    if (r_k == 6'd47) begin
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_index <= r_index + 8'd1;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    r_line_done <= 1'b1;
                    r_busy      <= 1'b0;
                    r_index     <= '0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.address_read_ent = r_address_read_ent;
    assign bus.lb_address       = r_lb_address;
    assign bus.lb_data          = r_lb_data;
    assign bus.lb_wren          = r_lb_wren;
    assign bus.busy             = r_busy;
    assign bus.line_done        = r_line_done;

endmodule

// File: tb/tb_entity_line_renderer.sv
// Testbench for entity_line_renderer: directed lines with a write/done scoreboard.
// Expected line-buffer writes and line_done cycles are queued at stimulus time.
// A negedge monitor pops and compares whenever the DUT writes or signals done.
module tb_entity_line_renderer;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

`ifdef ENT_CLEAR_EN
    localparam int CLR = 480;
`else
    localparam int CLR = 0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    entity_line_renderer_if bus ();

    entity_line_renderer dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    // Entity RAM model: synchronous read, data one cycle after the address.
    logic [20:0] ent_mem [0:255];
    always @(posedge clk) bus.data_read_ent <= ent_mem[bus.address_read_ent];

    typedef struct packed {
        logic [8:0] addr;
        logic [2:0] dat;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_done[$];
    wr_t mon_e;
    int  mon_c;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Monitor: compares every write and every line_done against the queues.
    always @(negedge clk) begin
        if (bus.lb_wren === 1'b1) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0d want no write",
                         bus.lb_address, bus.lb_data);
            end else begin
                mon_e = exp_wr.pop_front();
                chk("wr_addr", 32'(bus.lb_address), 32'(mon_e.addr));
                chk("wr_data", 32'(bus.lb_data), 32'(mon_e.dat));
            end
        end
        if (bus.line_done === 1'b1) begin
            if (exp_done.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got line_done at cycle %0d want none", cyc);
            end else begin
                mon_c = exp_done.pop_front();
                chk("done_cycle", 32'(cyc), 32'(mon_c));
                chk("busy_at_done", 32'(bus.busy), 32'd0);
            end
        end
    end

    task automatic push_clear();
`ifdef ENT_CLEAR_EN
        for (int i = 0; i < 480; i++) exp_wr.push_back({9'(i), 3'd0});
`endif
    endtask

    task automatic push_paint(input int col, input logic [2:0] t);
        for (int k = 0; k < 48; k++)
            if (col + k < 480) exp_wr.push_back({9'(col + k), t});
    endtask

    // cost: 3 cycles per record examined plus 48 per record painted.
    task automatic start_line(input int y, input int n, input int cost, input bit expect_done);
        @(negedge clk);
        bus.line_y          = 9'(y);
        bus.entities_number = 8'(n);
        bus.line_start      = 1'b1;
        push_clear();
        if (expect_done) exp_done.push_back(cyc + 2 + CLR + cost);
        @(negedge clk);
        bus.line_start = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (exp_done.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_done.size() != 0) begin
            errors++;
            $display("FAIL done_timeout: got no line_done in %0d cycles want line_done", budget);
            exp_done.delete();
        end
        repeat (2) @(negedge clk);
        chk("writes_drained", 32'(exp_wr.size()), 32'd0);
        exp_wr.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ent_mem[i] = 21'd0;
        bus.line_start      = 1'b1;   // held during reset, must be ignored
        bus.line_y          = 9'd0;
        bus.entities_number = 8'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.line_done), 32'd0);
        chk("rst_wren", 32'(bus.lb_wren), 32'd0);
        chk("rst_addr", 32'(bus.lb_address), 32'd0);
        chk("rst_data", 32'(bus.lb_data), 32'd0);
        chk("rst_raddr", 32'(bus.address_read_ent), 32'd0);
        bus.line_start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("start_in_reset_ignored", 32'(bus.busy), 32'd0);

        // No records: only the optional clear pass, then done.
        start_line(10, 0, 0, 1'b1);
        wait_idle(600);

        // One record {100,48,96}: row 50 hits, row 96 is just below the square.
        ent_mem[0] = {3'b100, 9'd48, 9'd96};
        start_line(50, 1, 51, 1'b1);
        push_paint(96, 3'b100);
        wait_idle(700);
        start_line(96, 1, 3, 1'b1);
        wait_idle(700);

        // Right-edge clipping: only columns 456..479 written, paint still 48 cycles.
        ent_mem[0] = {3'b011, 9'd0, 9'd456};
        start_line(0, 1, 51, 1'b1);
        push_paint(456, 3'b011);
        wait_idle(700);

        // Overlap in index order, types 111 and 110 skipped.
        ent_mem[0] = {3'b001, 9'd0, 9'd0};
        ent_mem[1] = {3'b010, 9'd0, 9'd24};
        ent_mem[2] = {3'b111, 9'd0, 9'd200};
        ent_mem[3] = {3'b110, 9'd0, 9'd300};
        start_line(5, 4, 51 + 51 + 3 + 3, 1'b1);
        push_paint(0, 3'b001);
        push_paint(24, 3'b010);
        wait_idle(800);

        // line_start while busy is ignored: one done, one set of writes.
        ent_mem[0] = {3'b100, 9'd48, 9'd96};
        start_line(50, 1, 51, 1'b1);
        push_paint(96, 3'b100);
        repeat (10) @(negedge clk);
        bus.line_y     = 9'd0;
        bus.line_start = 1'b1;
        @(negedge clk);
        bus.line_start = 1'b0;
        chk("busy_during_ignored_start", 32'(bus.busy), 32'd1);
        wait_idle(700);
        repeat (60) @(negedge clk);
        chk("idle_after_ignored_start", 32'(bus.busy), 32'd0);

        // Reset mid-paint: six paint writes land, then the line is abandoned silently.
        start_line(50, 1, 0, 1'b0);
        for (int k = 0; k < 6; k++) exp_wr.push_back({9'(96 + k), 3'b100});
        repeat (9 + CLR) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_wren", 32'(bus.lb_wren), 32'd0);
        chk("abort_done", 32'(bus.line_done), 32'd0);
        chk("abort_writes", 32'(exp_wr.size()), 32'd0);
        reset = 1'b0;
        repeat (60) @(negedge clk);

        // Fresh request after the abort renders normally.
        start_line(60, 1, 51, 1'b1);
        push_paint(96, 3'b100);
        wait_idle(700);

        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/entity_line_renderer.md
ENTITY_LINE_RENDERER -- requirements
Module: entity_line_renderer

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state on posedge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 line_start  input  1  one-cycle pulse requesting render of line line_y.
REQ-005 line_y  input  9  screen row 0..479, sampled on accepted line_start.
REQ-006 entities_number  input  8  record count, sampled on accepted line_start.
REQ-007 address_read_ent  output  8  entity RAM read address.
REQ-008 data_read_ent  input  21  record {type[20:18], row_pos[17:9], col_pos[8:0]}, valid exactly 1 cycle after address.
REQ-009 lb_address  output  9  line-buffer write column 0..479.
REQ-010 lb_data  output  3  pixel colour code.
REQ-011 lb_wren  output  1  line-buffer write strobe.
REQ-012 busy  output  1  high from accepted line_start until line_done.
REQ-013 line_done  output  1  one-cycle pulse, line complete.

Function
REQ-014 Each entity is a 48x48 square; board is 480x480 pixels.
REQ-015 FSM states: IDLE, CLEAR, FETCH, WAIT, CHECK, PAINT, DONE.
REQ-016 IDLE: line_start=1 latches line_y and entities_number, sets busy, goes to CLEAR (see REQ-028); line_start while busy is ignored.
REQ-017 CLEAR: writes lb_data=0 to columns 0..479, one per cycle, lb_wren=1, then FETCH with index 0.
REQ-018 If latched entities_number=0, after CLEAR go directly to DONE.
REQ-019 FETCH: drive address_read_ent=index for one cycle, go to WAIT; WAIT: one cycle; CHECK: data_read_ent is valid and evaluated.
REQ-020 CHECK hit condition: type not in {110,111} and row_pos <= line_y < row_pos+48, computed in 10-bit unsigned arithmetic (no wrap).
REQ-021 Hit: go to PAINT with column counter = col_pos; miss: increment index, FETCH, or DONE if index = entities_number-1.
REQ-022 PAINT: 48 cycles, lb_address=col_pos+k (k=0..47), lb_data=type, lb_wren=1 only when col_pos+k < 480 (10-bit compare); cycles with col>=480 hold lb_wren=0 but still count.
REQ-023 After PAINT: next index as in REQ-021; records painted in index order, later index overwrites earlier at same column.
REQ-024 DONE: line_done=1 for one cycle, busy=0 in same cycle, return to IDLE.
REQ-025 lb_wren=0 in IDLE, FETCH, WAIT, CHECK, DONE; lb_address/lb_data don't-care when lb_wren=0.
REQ-026 Worst-case latency line_start to line_done: 1+480+entities_number*(3+48)+1 cycles.

Reset
REQ-027 reset=1: state IDLE, busy=0, line_done=0, lb_wren=0, lb_address=0, lb_data=0, address_read_ent=0, index=0; reset mid-line aborts without line_done; line_start in the reset cycle is ignored.

Configuration
REQ-028 Macro ENT_CLEAR_EN: defined -> CLEAR state present as REQ-017; undefined -> CLEAR omitted, IDLE goes directly to FETCH (or DONE if entities_number=0), buffer contents from prior line retained where not painted, REQ-026 drops 480 cycles.

Verification
REQ-029 ENT_CLEAR_EN, entities_number=0, line_start y=10 -> 480 writes of 0, line_done 482 cycles after line_start, no RAM-driven writes.
REQ-030 One record {100,48,96}, line_y=50 -> writes columns 96..143 with data 100; line_y=96 -> no paint (96 = 48+48, miss).
REQ-031 Record {011,0,456}, line_y=0 -> writes columns 456..479 only (24 writes), PAINT still 48 cycles.
REQ-032 Records idx0 {001,0,0}, idx1 {010,0,24}, line_y=5 -> columns 24..47 end with 010 (last write wins), 0..23 with 001; type 111 record -> skipped.
REQ-033 Assert reset during PAINT -> next cycle busy=0, lb_wren=0, no line_done; fresh line_start renders correctly.
REQ-034 line_start pulsed while busy -> ignored; exactly one line_done per accepted request.
